// File: rtl/ahb_lite_mem_slave.sv
// AHB-Lite memory slave: word-organised internal array with byte-lane writes,
// WAIT_STATES wait cycles on every OKAY data phase and a two-cycle ERROR response.
module ahb_lite_mem_slave #(
   parameter int unsigned MEM_BYTES   = 1024,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic [2:0]  HBURST,
   input  logic [1:0]  HTRANS,
   input  logic [31:0] HWDATA,
   input  logic        HREADY,
   output logic        HREADYOUT,
   output logic        HRESP,
   output logic [31:0] HRDATA
);
   localparam int unsigned MEM_WORDS = MEM_BYTES / 4;
   localparam int unsigned IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   localparam int unsigned CNT_W     = 4;
   localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

   state_t             state, state_next;
   logic [CNT_W-1:0]   cnt, cnt_next;
   logic [IDX_W-1:0]   d_idx;
   logic [1:0]         d_lane;
   logic [1:0]         d_size;
   logic               d_write;
   logic               accept;
   logic               can_accept;
   logic               legal;
   logic [3:0]         be;
   logic [31:0]        mem [MEM_WORDS];
   logic               unused;

   assign unused     = ^{HBURST, HTRANS[0]};
   assign accept     = HSEL & HREADY & HTRANS[1];
   assign can_accept = (state == S_IDLE) || (state == S_DATA) || (state == S_ERR2);

   // Address-phase legality: range, size and natural alignment
   always_comb begin
      legal = 1'b1;
      if (HADDR >= 32'(MEM_BYTES))                   legal = 1'b0;
      if (HSIZE > 3'd2)                               legal = 1'b0;
      if ((HSIZE == 3'd1) && HADDR[0])                legal = 1'b0;
      if ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00))   legal = 1'b0;
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      HREADYOUT  = 1'b1;
      HRESP      = 1'b0;
      unique case (state)
         S_WAIT: begin
            HREADYOUT = 1'b0;
            if (cnt == '0) state_next = S_DATA;
            else           cnt_next   = cnt - 1'b1;
         end
         S_ERR1: begin
            HREADYOUT  = 1'b0;
            HRESP      = 1'b1;
            state_next = S_ERR2;
         end
         default: begin
            // IDLE, DATA and ERR2 all complete this cycle and may take a new address phase
            if (state == S_ERR2) HRESP = 1'b1;
            state_next = S_IDLE;
            if (accept) begin
               if (!legal) begin
                  state_next = S_ERR1;
               end else if (WAIT_STATES > 0) begin
                  state_next = S_WAIT;
                  cnt_next   = WAIT_LOAD;
               end else begin
                  state_next = S_DATA;
               end
            end
         end
      endcase
   end

   // Data-phase registers
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         d_idx   <= '0;
         d_lane  <= '0;
         d_size  <= '0;
         d_write <= 1'b0;
      end else if (accept && can_accept) begin
         d_idx   <= HADDR[IDX_W+1:2];
         d_lane  <= HADDR[1:0];
         d_size  <= HSIZE[1:0];
         d_write <= HWRITE;
      end
   end

   always_comb begin
      be = 4'b0000;
      unique case (d_size)
         2'd0:    be[d_lane] = 1'b1;
         2'd1:    be = d_lane[1] ? 4'b1100 : 4'b0011;
         default: be = 4'b1111;
      endcase
   end

   // Write commits on the edge that ends DATA; a reset on that edge aborts it
   always_ff @(posedge HCLK) begin
      if ((state == S_DATA) && d_write && !HRESET) begin
         for (int n = 0; n < 4; n++) begin
            if (be[n]) mem[d_idx][8*n +: 8] <= HWDATA[8*n +: 8];
         end
      end
   end

   assign HRDATA = ((state == S_DATA) && !d_write) ? mem[d_idx] : 32'h0;

endmodule
